// File: rtl/coproc_scheduler_pkg.sv
// Shared definitions for the matrix-coprocessor scheduler.
//   CU_OPW        opcode width of the control_unit op_code pins
//   OP_*          control_unit opcodes
//   sched_state_e scheduler FSM states (3-bit encoding)
//   rr_index      (base + offset) wrapped into 0..n-1, for base < n and offset < n
package coproc_scheduler_pkg;

    localparam int CU_OPW = 3;

    localparam logic [CU_OPW-1:0] OP_MAT_ADD   = 3'd0;
    localparam logic [CU_OPW-1:0] OP_MAT_SUB   = 3'd1;
    localparam logic [CU_OPW-1:0] OP_MAT_MUL   = 3'd2;
    localparam logic [CU_OPW-1:0] OP_SCALE     = 3'd3;
    localparam logic [CU_OPW-1:0] OP_TRANSPOSE = 3'd4;
    localparam logic [CU_OPW-1:0] OP_DET       = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_LO = 3'd2,
        S_WAIT_HI = 3'd3,
        S_RESP    = 3'd4
    } sched_state_e;

    // A single conditional subtraction suffices because both operands are below n.
    function automatic logic [2:0] rr_index(logic [2:0] base, int offset, int n);
        int s;
        s = int'(base) + offset;
        if (s >= n) s = s - n;
        return 3'(s);
    endfunction

endpackage

// File: rtl/coproc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        request vector
//   ptr        highest-priority index this round (must be < NREQ)
//   grant      one-hot winner, all-zero when no request is set
//   grant_idx  index of the winner, 0 when no request is set
module rr_arbiter
    import coproc_scheduler_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      ptr,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      grant_idx
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        // Scan from ptr upward with wrap; the first set bit wins.
        for (int k = 0; k < NREQ; k++) begin
            if (grant == '0 && |(req & (NREQ'(1) << rr_index(ptr, k, NREQ)))) begin
                grant     = NREQ'(1) << rr_index(ptr, k, NREQ);
                grant_idx = rr_index(ptr, k, NREQ);
            end
        end
    end

endmodule

// File: rtl/coproc_scheduler.sv
// Round-robin scheduler sharing one matrix-coprocessor control unit among NREQ requesters.
// Latches the winner's opcode, pulses cu_start, follows the cu_ready busy/done handshake
// and returns a one-cycle ack with overflow/timeout status to the granted requester.
//   clk, rst      clock; asynchronous active-low reset
//   req, req_op   level requests and per-requester opcodes (slice i = [i*OPW +: OPW])
//   ack           one-cycle completion pulse to the granted requester
//   rsp_ovf/tmo   status, valid only with ack
//   grant_id      current/last granted requester
//   busy          high from grant until ack, inclusive
//   cu_start/op   start pulse and held opcode to control_unit
//   cu_ready      control_unit ready (high = idle/done, low = computing)
//   cu_overflow   control_unit overflow flag, sampled when ready returns high
module coproc_scheduler
    import coproc_scheduler_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int OPW     = CU_OPW,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [NREQ-1:0]     ack,
    output logic                rsp_ovf,
    output logic                rsp_tmo,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic                cu_start,
    output logic [OPW-1:0]      cu_op,
    input  logic                cu_ready,
    input  logic                cu_overflow
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_e     state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic [OPW-1:0]   cu_op_q, cu_op_d;
    logic             busy_q, busy_d;
    logic             cu_start_q, cu_start_d;
    logic [NREQ-1:0]  ack_q, ack_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_tmo_q, rsp_tmo_d;

    logic [NREQ-1:0]  arb_grant;
    logic [2:0]       arb_idx;
    logic [NREQ-1:0]  ack_onehot;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign ack_onehot = NREQ'(1) << grant_id_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        grant_id_d = grant_id_q;
        cu_op_d    = cu_op_q;
        busy_d     = busy_q;
        cu_start_d = 1'b0;
        ack_d      = '0;
        rsp_ovf_d  = 1'b0;
        rsp_tmo_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // A CU still computing (e.g. left over from a reset) blocks new issues.
                if (|arb_grant && cu_ready) begin
                    grant_id_d = arb_idx;
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_grant[i]) cu_op_d = req_op[i*OPW +: OPW];
                    end
                    busy_d     = 1'b1;
                    cu_start_d = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!cu_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d     = ack_onehot;
                    rsp_tmo_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HI: begin
                if (cu_ready) begin
                    ack_d     = ack_onehot;
                    rsp_ovf_d = cu_overflow;
                    state_d   = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    ack_d     = ack_onehot;
                    rsp_tmo_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                ptr_d   = rr_index(grant_id_q, 1, NREQ);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every flop, outputs included, is reset so a mid-operation reset leaves no stale ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_id_q <= '0;
            cu_op_q    <= '0;
            busy_q     <= 1'b0;
            cu_start_q <= 1'b0;
            ack_q      <= '0;
            rsp_ovf_q  <= 1'b0;
            rsp_tmo_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling pre-edge values.
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant_id_q <= grant_id_d;
            cu_op_q    <= cu_op_d;
            busy_q     <= busy_d;
            cu_start_q <= cu_start_d;
            ack_q      <= ack_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_tmo_q  <= rsp_tmo_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_ovf  = rsp_ovf_q;
    assign rsp_tmo  = rsp_tmo_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign cu_start = cu_start_q;
    assign cu_op    = cu_op_q;

endmodule

// File: tb/tb_coproc_scheduler.sv
module tb_coproc_scheduler;

    localparam int NREQ    = 2;
    localparam int OPW     = 3;
    localparam int TIMEOUT = 16;
    localparam int K       = 5;   // cycles the CU model holds ready low

    localparam int CU_AUTO  = 0;  // drop ready after start, raise K cycles later
    localparam int CU_NEVER = 1;  // ignore start, ready stays high
    localparam int CU_HOLD  = 2;  // ready held low (CU not idle)

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [NREQ-1:0]     ack;
    logic                rsp_ovf, rsp_tmo, busy, cu_start;
    logic [2:0]          grant_id;
    logic [OPW-1:0]      cu_op;
    logic                cu_ready = 1'b1;
    logic                cu_overflow = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts = 0;
    int acks = 0;

    int   cu_mode = CU_AUTO;
    logic cu_ovf_flag = 1'b0;
    int   cu_left = 0;

    always #5 clk = ~clk;

    coproc_scheduler #(.NREQ(NREQ), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_op      (req_op),
        .ack         (ack),
        .rsp_ovf     (rsp_ovf),
        .rsp_tmo     (rsp_tmo),
        .grant_id    (grant_id),
        .busy        (busy),
        .cu_start    (cu_start),
        .cu_op       (cu_op),
        .cu_ready    (cu_ready),
        .cu_overflow (cu_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- control_unit model (acts 2 time units after each rising edge)
    always @(posedge clk) begin
        #2;
        case (cu_mode)
            CU_HOLD:  cu_ready <= 1'b0;
            CU_NEVER: begin cu_ready <= 1'b1; cu_overflow <= 1'b0; end
            default: begin
                if (cu_start) begin
                    cu_ready    <= 1'b0;
                    cu_overflow <= 1'b0;
                    cu_left     <= K;
                end else if (!cu_ready) begin
                    if (cu_left == 0) begin
                        cu_ready    <= 1'b1;
                        cu_overflow <= cu_ovf_flag;
                    end else begin
                        cu_left <= cu_left - 1;
                    end
                end
            end
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (cu_start) starts <= starts + 1;
        if (ack != '0) acks <= acks + 1;
    end

    // ---------------- behavioural model: one operation at a time, timed by wait counters
    logic           m_busy = 0, m_issue = 0, m_ack = 0, m_low = 0, m_ovf = 0, m_tmo = 0;
    int             m_since = 0, m_gid = 0, m_ptr = 0;
    logic [OPW-1:0] m_op = '0;
    logic           cmp_en = 0;

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return 0;
    endfunction

    function automatic logic [OPW-1:0] pick_op(input logic [NREQ*OPW-1:0] v, input int i);
        return v[i*OPW +: OPW];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_issue <= 0; m_ack <= 0; m_low <= 0; m_ovf <= 0; m_tmo <= 0;
            m_since <= 0; m_gid <= 0; m_ptr <= 0; m_op <= '0;
        end else if (m_ack) begin
            m_ack <= 0; m_ovf <= 0; m_tmo <= 0; m_busy <= 0;
            m_ptr <= (m_gid + 1) % NREQ;
        end else if (!m_busy) begin
            if (req != '0 && cu_ready) begin
                m_gid   <= rr_pick(req, m_ptr);
                m_op    <= pick_op(req_op, rr_pick(req, m_ptr));
                m_busy  <= 1;
                m_issue <= 1;
            end
        end else if (m_issue) begin
            m_issue <= 0; m_low <= 0; m_since <= 0;
        end else if (!m_low) begin
            if (!cu_ready) begin m_low <= 1; m_since <= 0; end
            else if (m_since + 1 == TIMEOUT) begin m_ack <= 1; m_tmo <= 1; end
            else m_since <= m_since + 1;
        end else begin
            if (cu_ready) begin m_ack <= 1; m_ovf <= cu_overflow; end
            else if (m_since + 1 == TIMEOUT) begin m_ack <= 1; m_tmo <= 1; end
            else m_since <= m_since + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ack", 32'(ack), m_ack ? (32'd1 << m_gid) : 32'd0);
            check("model_rsp_ovf", 32'(rsp_ovf), 32'(m_ack & m_ovf));
            check("model_rsp_tmo", 32'(rsp_tmo), 32'(m_ack & m_tmo));
            check("model_grant_id", 32'(grant_id), 32'(m_gid));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_cu_start", 32'(cu_start), 32'(m_issue));
            check("model_cu_op", 32'(cu_op), 32'(m_op));
        end
    end

    // ---------------- stimulus helpers
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        cu_mode = CU_AUTO;
        cu_ovf_flag = 1'b0;
        cycles(K + 4);
        rst = 1'b1;
    endtask

    task automatic wait_start(input int max, output logic ok, output int at, output logic [2:0] gid);
        ok = 0; at = 0; gid = '0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (cu_start) begin ok = 1; at = cyc; gid = grant_id; end
        end
    endtask

    task automatic wait_ack(input int max, output logic ok, output int at,
                            output logic [NREQ-1:0] av, output logic ovf, output logic tmo);
        ok = 0; at = 0; av = '0; ovf = 0; tmo = 0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (ack != '0) begin ok = 1; at = cyc; av = ack; ovf = rsp_ovf; tmo = rsp_tmo; end
        end
    endtask

    // ---------------- directed tests
    initial begin
        logic            ok;
        int              t0, ts, ta, s0, a0;
        logic [2:0]      g;
        logic [NREQ-1:0] av;
        logic            ovf, tmo;
        logic [2:0]      exp_seq [4];
        exp_seq[0] = 3'd0; exp_seq[1] = 3'd1; exp_seq[2] = 3'd0; exp_seq[3] = 3'd1;

        #1 rst = 1'b0;
        #1;
        check("reset_ack", 32'(ack), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_cu_start", 32'(cu_start), 0);
        check("reset_cu_op", 32'(cu_op), 0);
        check("reset_rsp", 32'({rsp_ovf, rsp_tmo}), 0);
        cmp_en = 1'b1;
        cycles(3);
        rst = 1'b1;

        // 1: single request, op 010, ack 8 cycles after req rises
        req_op = {3'b101, 3'b010};
        cycles(2);
        #1 s0 = starts;
        @(negedge clk);
        t0 = cyc;
        req = 2'b01;
        wait_start(10, ok, ts, g);
        check("t1_start_seen", 32'(ok), 1);
        check("t1_start_cycle", 32'(ts - t0), 1);
        check("t1_cu_op", 32'(cu_op), 32'h2);
        req_op[2:0] = 3'b111;
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t1_ack_seen", 32'(ok), 1);
        check("t1_ack_latency", 32'(ta - t0), 8);
        check("t1_ack_vec", 32'(av), 32'h1);
        check("t1_rsp_ovf", 32'(ovf), 0);
        req = '0;
        cycles(2);
        #1;
        check("t1_single_start", 32'(starts - s0), 1);
        check("t1_cu_op_held", 32'(cu_op), 32'h2);

        // 2: both requesting continuously after reset -> 0,1,0,1
        do_reset();
        req_op = {3'b100, 3'b001};
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_start(40, ok, ts, g);
            check("t2_start_seen", 32'(ok), 1);
            check("t2_grant_order", 32'(g), 32'(exp_seq[i]));
        end
        req = '0;
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t2_last_ack", 32'(av), 32'h2);
        cycles(2);

        // 3: overflow reported once, next op clean
        cu_ovf_flag = 1'b1;
        req = 2'b01;
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t3_ack_vec", 32'(av), 32'h1);
        check("t3_rsp_ovf", 32'(ovf), 1);
        check("t3_rsp_tmo", 32'(tmo), 0);
        req = '0;
        cu_ovf_flag = 1'b0;
        cycles(2);
        req = 2'b10;
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t3b_ack_vec", 32'(av), 32'h2);
        check("t3b_rsp_ovf", 32'(ovf), 0);
        req = '0;
        cycles(2);

        // 4: CU never drops ready -> timeout after TIMEOUT cycles in WAIT_LO
        cu_mode = CU_NEVER;
        req = 2'b01;
        wait_start(10, ok, ts, g);
        check("t4_start_seen", 32'(ok), 1);
        wait_ack(TIMEOUT + 10, ok, ta, av, ovf, tmo);
        check("t4_ack_seen", 32'(ok), 1);
        check("t4_tmo_latency", 32'(ta - ts), 32'(TIMEOUT + 1));
        check("t4_rsp_tmo", 32'(tmo), 1);
        check("t4_rsp_ovf", 32'(ovf), 0);
        req = '0;
        cu_mode = CU_AUTO;
        cycles(2);

        // 5: CU busy in IDLE blocks issue until ready returns
        cu_mode = CU_HOLD;
        cycles(2);
        #1 s0 = starts;
        @(negedge clk);
        req = 2'b01;
        cycles(10);
        #1;
        check("t5_no_start", 32'(starts - s0), 0);
        check("t5_not_busy", 32'(busy), 0);
        @(negedge clk);
        cu_mode = CU_AUTO;
        wait_start(5, ok, ts, g);
        check("t5_start_after_ready", 32'(ok), 1);
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t5_ack_vec", 32'(av), 32'h1);
        req = '0;
        cycles(2);

        // 6: async reset during WAIT_HI, no ack, fresh grant to 0 once the CU is idle
        req = 2'b01;
        wait_start(10, ok, ts, g);
        cycles(3);
        #1 a0 = acks;
        #1 rst = 1'b0;
        #1;
        check("t6_rst_ack", 32'(ack), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_cu_op", 32'(cu_op), 0);
        check("t6_rst_grant_id", 32'(grant_id), 0);
        check("t6_rst_cu_start", 32'(cu_start), 0);
        req = 2'b11;
        cycles(2);
        rst = 1'b1;
        wait_start(20, ok, ts, g);
        check("t6_restart_seen", 32'(ok), 1);
        check("t6_restart_grant", 32'(g), 0);
        #1;
        check("t6_no_stale_ack", 32'(acks - a0), 0);
        req = '0;
        wait_ack(40, ok, ta, av, ovf, tmo);
        check("t6_ack_vec", 32'(av), 32'h1);
        cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
